// File: rtl/subneg_pkg.sv
// -----------------------------------------------------------------------------
// subneg_pkg
// Shared definitions for the subneg external memory bus sequencer:
//   membus_state_t : sequencer state encoding
//   BUS_DRIVE/FLOAT: pad output-enable patterns
//   PORT_CPU/LD    : requester indices used by the arbiter and grant mux
//   WAIT_W         : width of the strobe wait down-counter
// -----------------------------------------------------------------------------
package subneg_pkg;

   localparam int          WAIT_W    = 4;
   localparam logic [7:0]  BUS_DRIVE = 8'hFF;
   localparam logic [7:0]  BUS_FLOAT = 8'h00;
   localparam logic        PORT_CPU  = 1'b0;
   localparam logic        PORT_LD   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_LATCH     = 3'd2,
      ST_RD        = 3'd3,
      ST_WR_SETUP  = 3'd4,
      ST_WR_STROBE = 3'd5,
      ST_WR_HOLD   = 3'd6,
      ST_DONE      = 3'd7
   } membus_state_t;

   // Load value for the strobe down-counter: strobe lasts wait_cycles+1 cycles.
   function automatic logic [WAIT_W-1:0] wait_load(input int wait_cycles);
      return wait_cycles[WAIT_W-1:0];
   endfunction

endpackage

// File: rtl/subneg_membus_arb.sv
// -----------------------------------------------------------------------------
// subneg_membus_arb
// Two-input arbiter for the memory bus (CPU port and loader port).
// Optional macro SUBNEG_MEMBUS_RR_EN selects round-robin arbitration;
// without it the loader has fixed priority.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   i_req[1:0]     : requests, indexed by PORT_CPU / PORT_LD
//   i_take         : sequencer accepts the grant this cycle
//   o_gnt          : granted port index (valid when o_gnt_valid)
//   o_gnt_valid    : at least one request pending
// -----------------------------------------------------------------------------
module subneg_membus_arb
   import subneg_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_gnt,
   output logic       o_gnt_valid
);

`ifdef SUBNEG_MEMBUS_RR_EN
   // Last-served port; reset to loader so the first contention goes to the CPU.
   logic r_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= PORT_LD;
      end else if (i_take && o_gnt_valid) begin
         r_last <= o_gnt;
      end
   end
`endif

   always_comb begin
      o_gnt_valid = |i_req;
      o_gnt       = PORT_CPU;
`ifdef SUBNEG_MEMBUS_RR_EN
      if (i_req[PORT_CPU] && i_req[PORT_LD]) begin
         o_gnt = ~r_last;
      end else if (i_req[PORT_LD]) begin
         o_gnt = PORT_LD;
      end
`else
      if (i_req[PORT_LD]) begin
         o_gnt = PORT_LD;
      end
`endif
   end

endmodule

// File: rtl/subneg_membus_ctrl.sv
// -----------------------------------------------------------------------------
// subneg_membus_ctrl
// Sequencer and two-port arbiter for the subneg core's multiplexed 8-bit
// memory bus (external address latch + SRAM). Turns single-word requests
// from the CPU port and the loader port into ADDR -> LATCH -> OE/WE cycles.
// Optional macro SUBNEG_MEMBUS_RR_EN: round-robin arbitration (default is
// fixed loader priority).
// Parameter: WAIT_CYCLES (0..15) extra cycles MOE/MWE stay asserted.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   cpu_req/we/addr/wdata/ack/rdata : CPU request port
//   ld_req/we/addr/wdata/ack/rdata  : loader/debug request port
//   bus_in, bus_out, bus_oe         : uio pad data in/out and enable
//   le, moe, mwe                    : latch enable, memory OE, memory WE
//   busy                            : sequencer not idle
//   owner_ld                        : loader owns current transaction
// All outputs are registered.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | bus floated, waiting for a request, arbitrate
// ST_ADDR      | address driven, LE high
// ST_LATCH     | LE low, address held for latch hold time
// ST_RD        | bus floated, MOE high for WAIT_CYCLES+1 cycles
// ST_WR_SETUP  | write data driven, MWE low
// ST_WR_STROBE | MWE high for WAIT_CYCLES+1 cycles
// ST_WR_HOLD   | MWE low, data held one cycle
// ST_DONE      | owner ack pulse, bus floated
// -----------------------------------------------------------------------------
module subneg_membus_ctrl
   import subneg_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_ack,
   output logic [7:0] cpu_rdata,
   input  logic       ld_req,
   input  logic       ld_we,
   input  logic [7:0] ld_addr,
   input  logic [7:0] ld_wdata,
   output logic       ld_ack,
   output logic [7:0] ld_rdata,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic [7:0] bus_oe,
   output logic       le,
   output logic       moe,
   output logic       mwe,
   output logic       busy,
   output logic       owner_ld
);

   localparam logic [WAIT_W-1:0] W_LOAD = wait_load(WAIT_CYCLES);

   membus_state_t     r_state;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_we;
   logic [7:0]        r_wdata;
   logic              r_owner_ld;
   logic [7:0]        r_bus_out;
   logic [7:0]        r_bus_oe;
   logic              r_le;
   logic              r_moe;
   logic              r_mwe;
   logic              r_busy;
   logic              r_cpu_ack;
   logic              r_ld_ack;
   logic [7:0]        r_cpu_rdata;
   logic [7:0]        r_ld_rdata;

   logic [1:0]        w_req;
   logic              w_take;
   logic              w_gnt;
   logic              w_gnt_valid;
   logic              w_sel_we;
   logic [7:0]        w_sel_addr;
   logic [7:0]        w_sel_wdata;

   assign w_req  = {ld_req, cpu_req};
   assign w_take = (r_state == ST_IDLE);

   subneg_membus_arb u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (w_req),
      .i_take      (w_take),
      .o_gnt       (w_gnt),
      .o_gnt_valid (w_gnt_valid)
   );

   assign w_sel_we    = (w_gnt == PORT_LD) ? ld_we    : cpu_we;
   assign w_sel_addr  = (w_gnt == PORT_LD) ? ld_addr  : cpu_addr;
   assign w_sel_wdata = (w_gnt == PORT_LD) ? ld_wdata : cpu_wdata;

   // Each branch sets the outputs for the state being entered, so every
   // pin is a flop and nothing from req reaches the pads combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_wdata     <= 8'h00;
         r_owner_ld  <= 1'b0;
         r_bus_out   <= 8'h00;
         r_bus_oe    <= BUS_FLOAT;
         r_le        <= 1'b0;
         r_moe       <= 1'b0;
         r_mwe       <= 1'b0;
         r_busy      <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_ld_ack    <= 1'b0;
         r_cpu_rdata <= 8'h00;
         r_ld_rdata  <= 8'h00;
      end else begin
         r_cpu_ack <= 1'b0;
         r_ld_ack  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_owner_ld <= (w_gnt == PORT_LD);
                  r_we       <= w_sel_we;
                  r_wdata    <= w_sel_wdata;
                  r_bus_out  <= w_sel_addr;
                  r_bus_oe   <= BUS_DRIVE;
                  r_le       <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               r_le    <= 1'b0;
               r_state <= ST_LATCH;
            end
            ST_LATCH: begin
               if (r_we) begin
                  r_bus_out <= r_wdata;
                  r_state   <= ST_WR_SETUP;
               end else begin
                  // Release the pads in the same edge MOE rises so the
                  // SRAM never drives against us.
                  r_bus_oe <= BUS_FLOAT;
                  r_moe    <= 1'b1;
                  r_cnt    <= W_LOAD;
                  r_state  <= ST_RD;
               end
            end
            ST_RD: begin
               if (r_cnt == '0) begin
                  r_moe <= 1'b0;
                  if (r_owner_ld) begin
                     r_ld_rdata <= bus_in;
                     r_ld_ack   <= 1'b1;
                  end else begin
                     r_cpu_rdata <= bus_in;
                     r_cpu_ack   <= 1'b1;
                  end
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_WR_SETUP: begin
               r_mwe   <= 1'b1;
               r_cnt   <= W_LOAD;
               r_state <= ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
               if (r_cnt == '0) begin
                  r_mwe   <= 1'b0;
                  r_state <= ST_WR_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_WR_HOLD: begin
               r_bus_oe <= BUS_FLOAT;
               if (r_owner_ld) begin
                  r_ld_ack <= 1'b1;
               end else begin
                  r_cpu_ack <= 1'b1;
               end
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_bus_oe <= BUS_FLOAT;
               r_le     <= 1'b0;
               r_moe    <= 1'b0;
               r_mwe    <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus_out   = r_bus_out;
   assign bus_oe    = r_bus_oe;
   assign le        = r_le;
   assign moe       = r_moe;
   assign mwe       = r_mwe;
   assign busy      = r_busy;
   assign owner_ld  = r_owner_ld;
   assign cpu_ack   = r_cpu_ack;
   assign ld_ack    = r_ld_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign ld_rdata  = r_ld_rdata;

endmodule

// File: tb/tb_subneg_membus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_subneg_membus_ctrl
// Three sequencer instances (WAIT_CYCLES = 1, 0, 3) on a shared clock and
// reset, each with its own latch + SRAM model on the bus pins.
// -----------------------------------------------------------------------------
module tb_subneg_membus_ctrl;

   localparam int NDUT = 3;

   function automatic int wv(input int k);
      case (k)
         0:       return 1;
         1:       return 0;
         default: return 3;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       cpu_req [NDUT];
   logic       cpu_we [NDUT];
   logic [7:0] cpu_addr [NDUT];
   logic [7:0] cpu_wdata [NDUT];
   logic       cpu_ack [NDUT];
   logic [7:0] cpu_rdata [NDUT];
   logic       ld_req [NDUT];
   logic       ld_we [NDUT];
   logic [7:0] ld_addr [NDUT];
   logic [7:0] ld_wdata [NDUT];
   logic       ld_ack [NDUT];
   logic [7:0] ld_rdata [NDUT];
   logic [7:0] bus_out [NDUT];
   logic [7:0] bus_oe [NDUT];
   logic       le [NDUT];
   logic       moe [NDUT];
   logic       mwe [NDUT];
   logic       busy [NDUT];
   logic       owner_ld [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      logic [7:0] mem [256];
      logic [7:0] lat = 8'h00;
      logic [7:0] w_bus_in;
      int         viol = 0;

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h76;
      end

      assign w_bus_in = moe[g] ? mem[lat] : 8'hEE;

      always @(posedge clk) begin
         if (le[g]) lat <= bus_out[g];
         if (mwe[g]) mem[lat] <= bus_out[g];
      end

      always @(negedge clk) begin
         if ((moe[g] && mwe[g]) || (moe[g] && bus_oe[g] != 8'h00)) viol++;
      end

      subneg_membus_ctrl #(.WAIT_CYCLES(wv(g))) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .cpu_req   (cpu_req[g]),
         .cpu_we    (cpu_we[g]),
         .cpu_addr  (cpu_addr[g]),
         .cpu_wdata (cpu_wdata[g]),
         .cpu_ack   (cpu_ack[g]),
         .cpu_rdata (cpu_rdata[g]),
         .ld_req    (ld_req[g]),
         .ld_we     (ld_we[g]),
         .ld_addr   (ld_addr[g]),
         .ld_wdata  (ld_wdata[g]),
         .ld_ack    (ld_ack[g]),
         .ld_rdata  (ld_rdata[g]),
         .bus_in    (w_bus_in),
         .bus_out   (bus_out[g]),
         .bus_oe    (bus_oe[g]),
         .le        (le[g]),
         .moe       (moe[g]),
         .mwe       (mwe[g]),
         .busy      (busy[g]),
         .owner_ld  (owner_ld[g])
      );
   end

   typedef struct {
      int         k;
      bit         ld;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } vec_t;

   typedef struct {
      bit         ld;
      logic [7:0] rdata;
      int         ack_cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] shadow [NDUT][256];
   logic [7:0] exp_cpu_rd [NDUT];
   logic [7:0] exp_ld_rd [NDUT];
   int         checks = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_rd_trackers();
      for (int k = 0; k < NDUT; k++) begin
         exp_cpu_rd[k] = 8'h00;
         exp_ld_rd[k]  = 8'h00;
      end
   endtask

   task automatic drop_req(input int k, input bit ld);
      if (ld) ld_req[k] = 1'b0;
      else    cpu_req[k] = 1'b0;
   endtask

   // Called just after a negedge with instance k idle; that cycle is cycle 0.
   task automatic do_txn(input int k, input bit ld, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input bit chg, input logic [7:0] alt,
                         input string tag);
      int          w;
      exp_t        e;
      logic [31:0] le_m, moe_m, mwe_m, oe_m, busy_m;
      logic [31:0] x_le, x_moe, x_mwe, x_oe, x_busy;
      bit          addr_ok, data_ok, other_ack;
      int          ack_c;
      logic        own;
      logic [7:0]  rd_at_ack;
      w = wv(k);
      le_m = 0; moe_m = 0; mwe_m = 0; oe_m = 0; busy_m = 0;
      addr_ok = 1; data_ok = 1; other_ack = 0; ack_c = -1; own = 1'bx; rd_at_ack = 8'h00;

      e.ld      = ld;
      e.ack_cyc = we ? 6 + w : 4 + w;
      e.rdata   = we ? (ld ? exp_ld_rd[k] : exp_cpu_rd[k]) : shadow[k][addr];
      sb.push_back(e);

      if (ld) begin
         ld_we[k] = we; ld_addr[k] = addr; ld_wdata[k] = wdata; ld_req[k] = 1'b1;
      end else begin
         cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wdata; cpu_req[k] = 1'b1;
      end

      for (int c = 1; c <= 30 && ack_c < 0; c++) begin
         @(negedge clk);
         le_m[c]   = le[k];
         moe_m[c]  = moe[k];
         mwe_m[c]  = mwe[k];
         oe_m[c]   = (bus_oe[k] == 8'hFF);
         busy_m[c] = busy[k];
         if (c == 1) own = owner_ld[k];
         if ((c == 1 || c == 2) && bus_out[k] !== addr) addr_ok = 0;
         if (we && c >= 3 && c <= 5 + w && bus_out[k] !== wdata) data_ok = 0;
         if (ld ? cpu_ack[k] : ld_ack[k]) other_ack = 1;
         if (chg && c == 1) begin
            if (ld) ld_addr[k] = alt;
            else    cpu_addr[k] = alt;
         end
         if (ld ? ld_ack[k] : cpu_ack[k]) begin
            ack_c = c;
            rd_at_ack = ld ? ld_rdata[k] : cpu_rdata[k];
            drop_req(k, ld);
         end
      end
      if (ack_c < 0) begin
         drop_req(k, ld);
         chk({tag, "_ack_timeout"}, 0, 1);
      end

      e = sb.pop_front();
      chk({tag, "_ack_cycle"}, ack_c, e.ack_cyc);
      chk({tag, "_rdata"}, rd_at_ack, e.rdata);
      chk({tag, "_owner_ld"}, own, e.ld);
      chk({tag, "_other_ack"}, other_ack, 0);
      chk({tag, "_addr_on_bus"}, addr_ok, 1);

      x_le   = 32'h2;
      x_moe  = we ? 0 : ((32'd1 << (w + 1)) - 1) << 3;
      x_mwe  = we ? ((32'd1 << (w + 1)) - 1) << 4 : 0;
      x_oe   = we ? ((32'd1 << (5 + w)) - 1) << 1 : 32'h6;
      x_busy = ((32'd1 << e.ack_cyc) - 1) << 1;
      chk({tag, "_le_cycles"}, le_m, x_le);
      chk({tag, "_moe_cycles"}, moe_m, x_moe);
      chk({tag, "_mwe_cycles"}, mwe_m, x_mwe);
      chk({tag, "_drive_cycles"}, oe_m, x_oe);
      chk({tag, "_busy_cycles"}, busy_m, x_busy);
      if (we) chk({tag, "_data_on_bus"}, data_ok, 1);

      if (we) shadow[k][addr] = wdata;
      else if (ld) exp_ld_rd[k] = e.rdata;
      else exp_cpu_rd[k] = e.rdata;

      @(negedge clk);
      chk({tag, "_idle_after"}, busy[k], 0);
      chk({tag, "_hold_cpu_rdata"}, cpu_rdata[k], exp_cpu_rd[k]);
      chk({tag, "_hold_ld_rdata"}, ld_rdata[k], exp_ld_rd[k]);
   endtask

   vec_t vecs [9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit         seen;
      int         winner;
      int         exp_win;
      logic       own1;

      vecs[0] = '{0, 1'b0, 1'b0, 8'h2A, 8'h00};
      vecs[1] = '{1, 1'b1, 1'b1, 8'h10, 8'hA5};
      vecs[2] = '{1, 1'b1, 1'b0, 8'h10, 8'h00};
      vecs[3] = '{2, 1'b0, 1'b0, 8'h7F, 8'h00};
      vecs[4] = '{0, 1'b0, 1'b1, 8'h44, 8'h3C};
      vecs[5] = '{0, 1'b1, 1'b0, 8'h44, 8'h00};
      vecs[6] = '{2, 1'b1, 1'b1, 8'hFF, 8'h01};
      vecs[7] = '{2, 1'b0, 1'b0, 8'hFF, 8'h00};
      vecs[8] = '{1, 1'b0, 1'b0, 8'h00, 8'h00};

      for (int k = 0; k < NDUT; k++) begin
         cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = 0; cpu_wdata[k] = 0;
         ld_req[k]  = 0; ld_we[k]  = 0; ld_addr[k]  = 0; ld_wdata[k]  = 0;
         for (int a = 0; a < 256; a++) shadow[k][a] = 8'(a) ^ 8'h76;
      end
      clear_rd_trackers();

      #2;
      for (int k = 0; k < NDUT; k++) begin
         chk("reset_bus_out", bus_out[k], 8'h00);
         chk("reset_bus_oe", bus_oe[k], 8'h00);
         chk("reset_strobes", {le[k], moe[k], mwe[k]}, 3'b000);
         chk("reset_busy_owner", {busy[k], owner_ld[k]}, 2'b00);
         chk("reset_acks", {cpu_ack[k], ld_ack[k]}, 2'b00);
         chk("reset_rdata", {cpu_rdata[k], ld_rdata[k]}, 16'h0000);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         do_txn(vecs[i].k, vecs[i].ld, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                1'b0, 8'h00, $sformatf("vec%0d", i));
      end

      // Address change after grant must not reach the bus.
      do_txn(0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h33, "addr_chg");

      // Reset in the middle of a write strobe.
      cpu_we[0] = 1'b1; cpu_addr[0] = 8'h50; cpu_wdata[0] = 8'h66; cpu_req[0] = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mwe[0]) seen = 1;
      end
      chk("rst_reach_strobe", seen, 1);
      chk("rst_pre_oe", bus_oe[0], 8'hFF);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_mwe", mwe[0], 0);
      chk("rst_async_oe", bus_oe[0], 8'h00);
      chk("rst_async_busy", busy[0], 0);
      chk("rst_async_ack", cpu_ack[0], 0);
      clear_rd_trackers();
      @(negedge clk);
      chk("rst_hold_ack", cpu_ack[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(0, 1'b0, 1'b1, 8'h50, 8'h66, 1'b0, 8'h00, "rst_retry");
      do_txn(0, 1'b0, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, "rst_readback");

      // Contention: both ports request in the same cycle, four rounds.
      rst_n = 1'b0;
      clear_rd_trackers();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
         cpu_we[0] = 1'b0; cpu_addr[0] = 8'h01; cpu_req[0] = 1'b1;
         ld_we[0]  = 1'b0; ld_addr[0]  = 8'h02; ld_req[0]  = 1'b1;
         winner = -1;
         own1 = 1'bx;
         for (int c = 1; c <= 30 && winner < 0; c++) begin
            @(negedge clk);
            if (c == 1) own1 = owner_ld[0];
            if (cpu_ack[0]) winner = 0;
            else if (ld_ack[0]) winner = 1;
         end
         cpu_req[0] = 1'b0;
         ld_req[0]  = 1'b0;
`ifdef SUBNEG_MEMBUS_RR_EN
         exp_win = r % 2;
`else
         exp_win = 1;
`endif
         chk($sformatf("arb_round%0d_winner", r), winner, exp_win);
         chk($sformatf("arb_round%0d_owner", r), own1, exp_win[0]);
         if (exp_win == 0) chk($sformatf("arb_round%0d_rdata", r), cpu_rdata[0], shadow[0][8'h01]);
         else              chk($sformatf("arb_round%0d_rdata", r), ld_rdata[0], shadow[0][8'h02]);
         @(negedge clk);
      end

      chk("proto_w1", g_dut[0].viol, 0);
      chk("proto_w0", g_dut[1].viol, 0);
      chk("proto_w3", g_dut[2].viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
